// File: rtl/color_proc_pkg.sv
// Shared encodings for the colour-threshold frame processor: FSM states and
// the output-mode codes selected by the mode input.
package color_proc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [1:0] MODE_PASS     = 2'b00;
   localparam logic [1:0] MODE_MASK     = 2'b01;
   localparam logic [1:0] MODE_BINARY   = 2'b10;
   localparam logic [1:0] MODE_MASK_ALT = 2'b11;

endpackage

// File: rtl/color_thr_cmp.sv
// Per-pixel window compare: each enabled channel must lie inside
// [thr_min, thr_max]; disabled channels always pass.
module color_thr_cmp #(
   parameter int c_nb_buf_red   = 4,
   parameter int c_nb_buf_green = 4,
   parameter int c_nb_buf_blue  = 4,
   parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue
) (
   input  logic [c_nb_buf-1:0] pxl,
   input  logic [c_nb_buf-1:0] thr_min,
   input  logic [c_nb_buf-1:0] thr_max,
   input  logic [2:0]          en,
   output logic                match
);

   logic [c_nb_buf_red-1:0]   red, red_lo, red_hi;
   logic [c_nb_buf_green-1:0] green, green_lo, green_hi;
   logic [c_nb_buf_blue-1:0]  blue, blue_lo, blue_hi;
   logic                      red_ok, green_ok, blue_ok;

   assign red      = pxl[c_nb_buf-1 -: c_nb_buf_red];
   assign red_lo   = thr_min[c_nb_buf-1 -: c_nb_buf_red];
   assign red_hi   = thr_max[c_nb_buf-1 -: c_nb_buf_red];
   assign green    = pxl[c_nb_buf_blue +: c_nb_buf_green];
   assign green_lo = thr_min[c_nb_buf_blue +: c_nb_buf_green];
   assign green_hi = thr_max[c_nb_buf_blue +: c_nb_buf_green];
   assign blue     = pxl[0 +: c_nb_buf_blue];
   assign blue_lo  = thr_min[0 +: c_nb_buf_blue];
   assign blue_hi  = thr_max[0 +: c_nb_buf_blue];

   // An inverted window (lo > hi) can never be satisfied, so no special case is needed.
   assign red_ok   = !en[2] || ((red   >= red_lo)   && (red   <= red_hi));
   assign green_ok = !en[1] || ((green >= green_lo) && (green <= green_hi));
   assign blue_ok  = !en[0] || ((blue  >= blue_lo)  && (blue  <= blue_hi));

   assign match = red_ok && green_ok && blue_ok;

endmodule

// File: rtl/color_thr_proc.sv
// Frame processor: streams a source image through a colour-window compare,
// writes the processed image and publishes match count and bounding box.
module color_thr_proc
   import color_proc_pkg::*;
#(
   parameter int c_img_cols     = 80,
   parameter int c_img_rows     = 60,
   parameter int c_nb_cols      = 7,
   parameter int c_nb_rows      = 6,
   parameter int c_nb_img_pxls  = 13,
   parameter int c_nb_buf_red   = 4,
   parameter int c_nb_buf_green = 4,
   parameter int c_nb_buf_blue  = 4,
   parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic [2:0]               rgbfilter,
   input  logic [c_nb_buf-1:0]      thr_min,
   input  logic [c_nb_buf-1:0]      thr_max,
   output logic [c_nb_img_pxls-1:0] orig_addr,
   input  logic [c_nb_buf-1:0]      orig_pxl,
   output logic                     proc_we,
   output logic [c_nb_img_pxls-1:0] proc_addr,
   output logic [c_nb_buf-1:0]      proc_pxl,
   output logic                     busy,
   output logic                     done,
   output logic [c_nb_img_pxls-1:0] match_cnt,
   output logic                     bbox_valid,
   output logic [c_nb_cols-1:0]     bbox_cmin,
   output logic [c_nb_cols-1:0]     bbox_cmax,
   output logic [c_nb_rows-1:0]     bbox_rmin,
   output logic [c_nb_rows-1:0]     bbox_rmax
);

   localparam int c_img_pxls = c_img_cols * c_img_rows;
   localparam logic [c_nb_img_pxls-1:0] LAST_ADDR = c_nb_img_pxls'(c_img_pxls - 1);
   localparam logic [c_nb_cols-1:0]     COL_LAST  = c_nb_cols'(c_img_cols - 1);

   state_t state, state_nxt;
   logic   accept, scan, frame_end;

   logic [1:0]          mode_q;
   logic [2:0]          filt_q;
   logic [c_nb_buf-1:0] tmin_q, tmax_q;
   logic [c_nb_cols-1:0] col;
   logic [c_nb_rows-1:0] row;

   logic                     vld_p0;
   logic [c_nb_img_pxls-1:0] addr_p0;
   logic [c_nb_cols-1:0]     col_p0;
   logic [c_nb_rows-1:0]     row_p0;
   logic                     match_p0;

   logic [c_nb_img_pxls-1:0] acc_cnt;
   logic [c_nb_cols-1:0]     acc_cmin, acc_cmax;
   logic [c_nb_rows-1:0]     acc_rmin, acc_rmax;

   function automatic logic [c_nb_buf-1:0] shade(input logic [1:0] m,
                                                  input logic hit,
                                                  input logic [c_nb_buf-1:0] px);
      logic [c_nb_buf-1:0] res;
      case (m)
         MODE_PASS:   res = px;
         MODE_BINARY: res = hit ? {c_nb_buf{1'b1}} : '0;
         default:     res = hit ? px : '0;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SCAN;
         ST_SCAN:  if (orig_addr == LAST_ADDR) state_nxt = ST_FLUSH;
         ST_FLUSH: if (!vld_p0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FLUSH ends when the pipeline has drained: the final write is on proc_we right now.
   always_comb begin
      accept    = 1'b0;
      scan      = 1'b0;
      frame_end = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE:  accept = start;
         ST_SCAN:  begin busy = 1'b1; scan = 1'b1; end
         ST_FLUSH: begin busy = 1'b1; frame_end = !vld_p0; end
         default:  ;
      endcase
   end

   // issue stage: address generation and per-frame configuration latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orig_addr <= '0;
         col       <= '0;
         row       <= '0;
         mode_q    <= '0;
         filt_q    <= '0;
         tmin_q    <= '0;
         tmax_q    <= '0;
      end else if (accept) begin
         orig_addr <= '0;
         col       <= '0;
         row       <= '0;
         mode_q    <= mode;
         filt_q    <= rgbfilter;
         tmin_q    <= thr_min;
         tmax_q    <= thr_max;
      end else if (scan && (orig_addr != LAST_ADDR)) begin
         orig_addr <= orig_addr + c_nb_img_pxls'(1);
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + c_nb_rows'(1);
         end else begin
            col <= col + c_nb_cols'(1);
         end
      end
   end

   // p0: source memory latency; position travels with the pixel being read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         addr_p0 <= '0;
         col_p0  <= '0;
         row_p0  <= '0;
      end else begin
         vld_p0  <= scan;
         addr_p0 <= orig_addr;
         col_p0  <= col;
         row_p0  <= row;
      end
   end

   color_thr_cmp #(
      .c_nb_buf_red   (c_nb_buf_red),
      .c_nb_buf_green (c_nb_buf_green),
      .c_nb_buf_blue  (c_nb_buf_blue),
      .c_nb_buf       (c_nb_buf)
   ) u_cmp (
      .pxl     (orig_pxl),
      .thr_min (tmin_q),
      .thr_max (tmax_q),
      .en      (filt_q),
      .match   (match_p0)
   );

   // p1: registered compare result drives the destination write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proc_we   <= 1'b0;
         proc_addr <= '0;
         proc_pxl  <= '0;
      end else begin
         proc_we   <= vld_p0;
         proc_addr <= vld_p0 ? addr_p0 : '0;
         proc_pxl  <= vld_p0 ? shade(mode_q, match_p0, orig_pxl) : '0;
      end
   end

   // First match seeds the box so the accumulators never need sentinel values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt  <= '0;
         acc_cmin <= '0;
         acc_cmax <= '0;
         acc_rmin <= '0;
         acc_rmax <= '0;
      end else if (accept) begin
         acc_cnt  <= '0;
         acc_cmin <= '0;
         acc_cmax <= '0;
         acc_rmin <= '0;
         acc_rmax <= '0;
      end else if (vld_p0 && match_p0) begin
         acc_cnt <= acc_cnt + c_nb_img_pxls'(1);
         if (acc_cnt == '0) begin
            acc_cmin <= col_p0;
            acc_cmax <= col_p0;
            acc_rmin <= row_p0;
            acc_rmax <= row_p0;
         end else begin
            if (col_p0 < acc_cmin) acc_cmin <= col_p0;
            if (col_p0 > acc_cmax) acc_cmax <= col_p0;
            if (row_p0 < acc_rmin) acc_rmin <= row_p0;
            if (row_p0 > acc_rmax) acc_rmax <= row_p0;
         end
      end
   end

   // Published statistics change only on the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done       <= 1'b0;
         match_cnt  <= '0;
         bbox_valid <= 1'b0;
         bbox_cmin  <= '0;
         bbox_cmax  <= '0;
         bbox_rmin  <= '0;
         bbox_rmax  <= '0;
      end else begin
         done <= frame_end;
         if (frame_end) begin
            match_cnt  <= acc_cnt;
            bbox_valid <= (acc_cnt != '0);
            bbox_cmin  <= acc_cmin;
            bbox_cmax  <= acc_cmax;
            bbox_rmin  <= acc_rmin;
            bbox_rmax  <= acc_rmax;
         end
      end
   end

endmodule

// File: tb/tb_color_thr_proc.sv
// Directed and randomized frames for color_thr_proc, checked against a
// whole-frame reference model computed from the window/mode rules.
module tb_color_thr_proc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  mode;
   logic [2:0]  rgbfilter;
   logic [11:0] thr_min, thr_max;
   logic [12:0] orig_addr;
   logic [11:0] orig_pxl;
   logic        proc_we;
   logic [12:0] proc_addr;
   logic [11:0] proc_pxl;
   logic        busy, done;
   logic [12:0] match_cnt;
   logic        bbox_valid;
   logic [6:0]  bbox_cmin, bbox_cmax;
   logic [5:0]  bbox_rmin, bbox_rmax;

   logic [11:0] mem [0:8191];
   logic [11:0] got [0:4799];
   int passes = 0;
   int fails  = 0;
   int total  = 0;

   color_thr_proc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rgbfilter(rgbfilter),
      .thr_min(thr_min), .thr_max(thr_max), .orig_addr(orig_addr), .orig_pxl(orig_pxl),
      .proc_we(proc_we), .proc_addr(proc_addr), .proc_pxl(proc_pxl), .busy(busy),
      .done(done), .match_cnt(match_cnt), .bbox_valid(bbox_valid),
      .bbox_cmin(bbox_cmin), .bbox_cmax(bbox_cmax), .bbox_rmin(bbox_rmin), .bbox_rmax(bbox_rmax)
   );

   always #5 clk = ~clk;

   // synchronous source memory: data one cycle after address
   always @(posedge clk) orig_pxl <= mem[orig_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_match(logic [11:0] p, logic [11:0] lo, logic [11:0] hi, logic [2:0] f);
      for (int c = 0; c < 3; c++) begin
         int sh = 8 - 4 * c;
         int v  = (int'(p)  >> sh) & 15;
         int l  = (int'(lo) >> sh) & 15;
         int h  = (int'(hi) >> sh) & 15;
         if (f[2 - c] && !(v >= l && v <= h)) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [11:0] model_out(logic [1:0] m, bit hit, logic [11:0] p);
      if (m == 2'b00) return p;
      if (m == 2'b10) return hit ? 12'hFFF : 12'h000;
      return hit ? p : 12'h000;
   endfunction

   function automatic logic [11:0] rand_lo_hi(bit want_hi, int seed_lo [3], int seed_hi [3]);
      logic [11:0] r;
      for (int c = 0; c < 3; c++) r[8 - 4 * c +: 4] = want_hi ? 4'(seed_hi[c]) : 4'(seed_lo[c]);
      return r;
   endfunction

   task automatic rand_window(output logic [11:0] lo, output logic [11:0] hi);
      int a [3];
      int b [3];
      for (int c = 0; c < 3; c++) begin
         a[c] = $urandom_range(0, 12);
         b[c] = $urandom_range(a[c], 15);
      end
      lo = rand_lo_hi(1'b0, a, b);
      hi = rand_lo_hi(1'b1, a, b);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 8192; i++) mem[i] = 12'($urandom);
   endtask

   task automatic drive_cfg(input logic [1:0] m, input logic [2:0] f, input logic [11:0] lo, input logic [11:0] hi);
      mode = m; rgbfilter = f; thr_min = lo; thr_max = hi;
   endtask

   task automatic run_frame(input string tag, input bit pulse,
                            input logic [1:0] e_mode, input logic [2:0] e_filt,
                            input logic [11:0] e_min, input logic [11:0] e_max,
                            input int inj_cycle, input bit inj_start,
                            input logic [1:0] i_mode, input logic [2:0] i_filt,
                            input logic [11:0] i_min, input logic [11:0] i_max,
                            input int rst_addr, input bit chain);
      int wr_cnt, seq_err, lat_err, pix_err, first_we, last_we, done_at, busy_gap, extra;
      int ecnt, ecmin, ecmax, ermin, ermax;
      logic [12:0] h1, h2;
      logic busy_done;
      bit m;
      wr_cnt = 0; seq_err = 0; lat_err = 0; pix_err = 0; first_we = -1; last_we = -10;
      done_at = -1; busy_gap = 0; h1 = '0; h2 = '0; busy_done = 1'bx;
      if (pulse) begin
         chk({tag, "_idle_busy"}, busy, 1'b0);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 0) chk({tag, "_busy_rise"}, busy, 1'b1);
         if (inj_cycle >= 0 && cyc == inj_cycle) begin
            start = inj_start;
            drive_cfg(i_mode, i_filt, i_min, i_max);
         end
         if (inj_cycle >= 0 && cyc == inj_cycle + 1) start = 1'b0;
         if (rst_addr >= 0 && busy && orig_addr == 13'(rst_addr)) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_rst_orig_addr"}, orig_addr, 0);
            chk({tag, "_rst_proc_we"}, proc_we, 0);
            chk({tag, "_rst_proc_addr"}, proc_addr, 0);
            chk({tag, "_rst_proc_pxl"}, proc_pxl, 0);
            chk({tag, "_rst_busy"}, busy, 0);
            chk({tag, "_rst_match_cnt"}, match_cnt, 0);
            chk({tag, "_rst_bbox_valid"}, bbox_valid, 0);
            chk({tag, "_rst_bbox"}, {bbox_cmin, bbox_cmax, bbox_rmin, bbox_rmax}, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            extra = 0;
            repeat (8) begin
               @(negedge clk);
               if (done || busy || proc_we) extra++;
            end
            chk({tag, "_rst_quiet"}, extra, 0);
            chk({tag, "_rst_no_partial_stats"}, match_cnt, 0);
            return;
         end
         if (proc_we) begin
            if (proc_addr != 13'(wr_cnt)) seq_err++;
            if (proc_addr != h2) lat_err++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (wr_cnt < 4800) got[wr_cnt] = proc_pxl;
            wr_cnt++;
         end
         if (done) begin
            done_at = cyc;
            busy_done = busy;
            if (chain) start = 1'b1;
            break;
         end
         if (!busy) busy_gap++;
         h2 = h1;
         h1 = orig_addr;
      end
      chk({tag, "_done_seen"}, done_at >= 0, 1'b1);

      ecnt = 0; ecmin = 0; ecmax = 0; ermin = 0; ermax = 0;
      for (int i = 0; i < 4800; i++) begin
         m = model_match(mem[i], e_min, e_max, e_filt);
         if (i < wr_cnt && got[i] !== model_out(e_mode, m, mem[i])) pix_err++;
         if (m) begin
            if (ecnt == 0) begin
               ecmin = i % 80; ecmax = i % 80; ermin = i / 80; ermax = i / 80;
            end else begin
               if (i % 80 < ecmin) ecmin = i % 80;
               if (i % 80 > ecmax) ecmax = i % 80;
               if (i / 80 < ermin) ermin = i / 80;
               if (i / 80 > ermax) ermax = i / 80;
            end
            ecnt++;
         end
      end
      chk({tag, "_write_count"}, wr_cnt, 4800);
      chk({tag, "_write_contiguous"}, last_we - first_we + 1, 4800);
      chk({tag, "_write_order"}, seq_err, 0);
      chk({tag, "_latency2"}, lat_err, 0);
      chk({tag, "_pixels"}, pix_err, 0);
      chk({tag, "_done_after_last_write"}, done_at, last_we + 1);
      chk({tag, "_busy_during"}, busy_gap, 0);
      chk({tag, "_busy_at_done"}, busy_done, 1'b0);
      chk({tag, "_match_cnt"}, match_cnt, ecnt);
      chk({tag, "_bbox_valid"}, bbox_valid, ecnt != 0);
      chk({tag, "_bbox_cols"}, {bbox_cmin, bbox_cmax}, {7'(ecmin), 7'(ecmax)});
      chk({tag, "_bbox_rows"}, {bbox_rmin, bbox_rmax}, {6'(ermin), 6'(ermax)});
      if (chain) begin
         @(negedge clk);
         start = 1'b0;
      end else begin
         extra = 0;
         repeat (5) begin
            @(negedge clk);
            if (done) extra++;
         end
         chk({tag, "_single_done"}, extra, 0);
         chk({tag, "_stats_held"}, match_cnt, ecnt);
      end
   endtask

   initial begin
      logic [1:0]  rm, im;
      logic [2:0]  rf, ifl;
      logic [11:0] lo, hi, ilo, ihi;
      rst_n = 1'b0;
      start = 1'b0;
      drive_cfg(2'b00, 3'b000, 12'h000, 12'h000);
      for (int i = 0; i < 8192; i++) mem[i] = 12'h000;
      repeat (3) @(negedge clk);
      chk("reset_orig_addr", orig_addr, 0);
      chk("reset_proc", {proc_we, proc_addr, proc_pxl}, 0);
      chk("reset_busy_done", {busy, done}, 0);
      chk("reset_stats", {match_cnt, bbox_valid, bbox_cmin, bbox_cmax, bbox_rmin, bbox_rmax}, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_after_reset", {busy, proc_we, done}, 0);

      // ramp image, pass-through, every pixel matches
      for (int i = 0; i < 8192; i++) mem[i] = 12'(i);
      drive_cfg(2'b00, 3'b000, 12'h000, 12'h000);
      run_frame("ramp", 1'b1, 2'b00, 3'b000, 12'h000, 12'h000,
                -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, -1, 1'b0);
      chk("ramp_bbox_abs", {bbox_cmin, bbox_cmax, bbox_rmin, bbox_rmax}, {7'd0, 7'd79, 6'd0, 6'd59});

      // single red pixel at (10,5), binary mode
      for (int i = 0; i < 8192; i++) mem[i] = 12'h000;
      mem[410] = 12'hF00;
      drive_cfg(2'b10, 3'b100, 12'h800, 12'hF00);
      run_frame("single", 1'b1, 2'b10, 3'b100, 12'h800, 12'hF00,
                -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, -1, 1'b0);
      chk("single_pix410", got[410], 12'hFFF);
      chk("single_pix409", got[409], 12'h000);
      chk("single_abs", {match_cnt, bbox_cmin, bbox_cmax, bbox_rmin, bbox_rmax},
          {13'd1, 7'd10, 7'd10, 6'd5, 6'd5});

      // inverted window never matches
      fill_random();
      drive_cfg(2'b01, 3'b100, 12'h900, 12'h100);
      run_frame("inverted", 1'b1, 2'b01, 3'b100, 12'h900, 12'h100,
                -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, -1, 1'b0);
      chk("inverted_abs", {match_cnt, bbox_valid, bbox_cmin, bbox_cmax, bbox_rmin, bbox_rmax}, 0);

      for (int k = 0; k < 3; k++) begin
         fill_random();
         rm = 2'($urandom); rf = 3'($urandom);
         rand_window(lo, hi);
         drive_cfg(rm, rf, lo, hi);
         run_frame($sformatf("rand%0d", k), 1'b1, rm, rf, lo, hi,
                   -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, -1, 1'b0);
      end

      // restart and new settings mid-frame are ignored
      fill_random();
      rm = 2'($urandom); rand_window(lo, hi);
      drive_cfg(rm, 3'b000, lo, hi);
      run_frame("midstart", 1'b1, rm, 3'b000, lo, hi,
                100, 1'b1, ~rm, 3'b111, 12'hFFF, 12'h000, -1, 1'b0);

      // asynchronous reset at address 2000, then a clean frame
      rm = 2'($urandom); rf = 3'($urandom); rand_window(lo, hi);
      drive_cfg(rm, rf, lo, hi);
      run_frame("midreset", 1'b1, rm, rf, lo, hi,
                -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, 2000, 1'b0);
      run_frame("after_reset", 1'b1, rm, rf, lo, hi,
                -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, -1, 1'b0);

      // back-to-back: second frame accepted on the done cycle with new inputs
      fill_random();
      rm = 2'($urandom); rf = 3'($urandom); rand_window(lo, hi);
      im = 2'($urandom); ifl = 3'($urandom); rand_window(ilo, ihi);
      drive_cfg(rm, rf, lo, hi);
      run_frame("b2b_first", 1'b1, rm, rf, lo, hi,
                50, 1'b0, im, ifl, ilo, ihi, -1, 1'b1);
      run_frame("b2b_second", 1'b0, im, ifl, ilo, ihi,
                -1, 1'b0, 2'b00, 3'b000, 12'h000, 12'h000, -1, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
